// File: rtl/mini_cpu_pkg.sv
// Shared mini-cpu constants: datapath width and data memory geometry.
package mini_cpu_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned DMEM_DEPTH = 1024;
  localparam int unsigned DMEM_IDX_W = $clog2(DMEM_DEPTH);

endpackage : mini_cpu_pkg

// File: rtl/data_mem.sv
// Word-addressed data memory: DEPTH doublewords held in flops so the whole array can be
// cleared synchronously. Stores commit on the rising edge; loads are combinational.
module data_mem #(
  parameter int unsigned XLEN  = mini_cpu_pkg::XLEN,
  parameter int unsigned DEPTH = mini_cpu_pkg::DMEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  input  logic            write_en,
  input  logic            read_en,
  output logic [XLEN-1:0] read_data
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [IdxW-1:0] idx;

  // Low three bits force doubleword alignment; bits above the index wrap the address space.
  assign idx = address[IdxW+2:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[XLEN-1:IdxW+3], address[2:0]};

  // Array update: reset clears every word and overrides any store on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_en) begin
      mem_q[idx] <= write_data;
    end
  end

  // Combinational load, gated to zero when not reading.
  always_comb begin
    read_data = '0;
    if (read_en) begin
      read_data = mem_q[idx];
    end
  end

endmodule : data_mem

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: hand sequences for reset and same-cycle corners plus a
// table of write/read vectors, with expected read data queued and compared on sampling.
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        write_en;
  logic        read_en;
  logic [63:0] read_data;

  int checks;
  int errors;

  logic [63:0] exp_q [$];

  data_mem dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .read_data  (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic        re;
    logic [63:0] raddr;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it against the current read data.
  task automatic score(input string name);
    logic [63:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, read_data=%h", name, read_data);
    end else begin
      exp = exp_q.pop_front();
      if (read_data !== exp) begin
        errors++;
        $display("FAIL %s: read_data=%h expected=%h", name, read_data, exp);
      end
    end
  endtask

  // Present a load, queue its expected result, and sample once the combinational path settles.
  task automatic expect_read(input logic [63:0] addr, input logic re, input logic [63:0] exp,
                             input string name);
    address = addr;
    read_en = re;
    exp_q.push_back(exp);
    #1;
    score(name);
  endtask

  task automatic write_word(input logic [63:0] addr, input logic [63:0] data);
    address    = addr;
    write_data = data;
    write_en   = 1'b1;
    tick();
    write_en   = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    address    = 64'd8;
    write_data = 64'd5;
    write_en   = 1'b1;
    read_en    = 1'b0;

    // Store held through two reset edges must be discarded.
    tick();
    tick();
    expect_read(64'd8, 1'b1, 64'd0, "rst_wr_suppressed");
    for (int i = 0; i < 1024; i++) begin
      expect_read(64'(i) * 64'd8, 1'b1, 64'd0, $sformatf("rst_clear_%0d", i));
    end

    // First edge after release is a normal edge: the held store commits.
    address = 64'd8;
    read_en = 1'b0;
    rst     = 1'b0;
    tick();
    write_en = 1'b0;
    expect_read(64'd8, 1'b1, 64'd5, "release_write");
    expect_read(64'd0, 1'b1, 64'd0, "release_other_zero");

    // Read enable gating within a single cycle.
    expect_read(64'd8, 1'b0, 64'd0, "read_disabled");
    expect_read(64'd8, 1'b1, 64'd5, "read_enabled_same_cycle");

    vecs.push_back('{1'b1, 64'd16, 64'hDEADBEEF_00000001, 1'b1, 64'd17,
                     64'hDEADBEEF_00000001, "align_17"});
    vecs.push_back('{1'b0, 64'd0, 64'd0, 1'b1, 64'd23, 64'hDEADBEEF_00000001, "align_23"});
    vecs.push_back('{1'b0, 64'd0, 64'd0, 1'b1, 64'd16 + 64'd8192,
                     64'hDEADBEEF_00000001, "wrap_8208"});
    vecs.push_back('{1'b0, 64'd0, 64'd0, 1'b1, 64'd24, 64'd0, "next_word_24"});
    vecs.push_back('{1'b0, 64'd0, 64'd0, 1'b0, 64'd16, 64'd0, "re0_masks_16"});
    vecs.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_1234, 1'b1, 64'd8184,
                     64'h0000_0000_0000_1234, "top_index_wrap"});
    vecs.push_back('{1'b1, 64'd8192 + 64'd24, 64'h33, 1'b1, 64'd24, 64'h33, "wrap_write_24"});
    vecs.push_back('{1'b1, 64'd8, 64'hAAAA_5555_AAAA_5555, 1'b1, 64'd12,
                     64'hAAAA_5555_AAAA_5555, "overwrite_8"});
    vecs.push_back('{1'b0, 64'd0, 64'd0, 1'b1, 64'd16, 64'hDEADBEEF_00000001, "kept_16"});

    foreach (vecs[k]) begin
      if (vecs[k].we) begin
        write_word(vecs[k].waddr, vecs[k].wdata);
      end
      expect_read(vecs[k].raddr, vecs[k].re, vecs[k].exp, vecs[k].name);
    end

    // Load and store to the same word: old value before the edge, new value after.
    write_word(64'd16, 64'd7);
    address    = 64'd16;
    read_en    = 1'b1;
    write_data = 64'd9;
    write_en   = 1'b1;
    expect_read(64'd16, 1'b1, 64'd7, "rw_pre_edge");
    tick();
    write_en = 1'b0;
    expect_read(64'd16, 1'b1, 64'd9, "rw_post_edge");

    // Reset mid-run clears filled words and drops the store sampled on the same edge.
    for (int i = 0; i < 4; i++) begin
      write_word(64'(i) * 64'd8, 64'h100 + 64'(i));
    end
    expect_read(64'd24, 1'b1, 64'h103, "fill_3");
    rst        = 1'b1;
    address    = 64'd8;
    write_data = 64'hBAD;
    write_en   = 1'b1;
    tick();
    rst      = 1'b0;
    write_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_read(64'(i) * 64'd8, 1'b1, 64'd0, $sformatf("midrun_clear_%0d", i));
    end
    expect_read(64'd8184, 1'b1, 64'd0, "midrun_clear_1023");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_mem
